// File: rtl/edgcol_hb_engine.sv
// Xedgcol hit-box engine: 16-entry edge table scanned one entry per cycle against a latched hit box.
// Latency: hb_done 16 cycles after the accepted start; starts and table writes are ignored while busy.
module edgcol_hb_engine #(
  parameter int NUM_EDGES = 16,
  parameter int COORD_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        edge_wr_en,
  input  logic [3:0]  edge_wr_idx,
  input  logic [31:0] edge_wr_data,
  input  logic        edge_clr,
  input  logic        hb_start,
  input  logic [31:0] hitbox,
  output logic        hb_done,
  output logic [31:0] hb_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [31:0]            hb_q, hb_d;
  logic [NUM_EDGES-1:0]   mask_q, mask_d;
  logic                   any_q, any_d;
  logic                   done_q, done_d;
  logic [NUM_EDGES-1:0]   valid_q, valid_d;
  logic [31:0]            tbl_q [NUM_EDGES];

  logic                   tbl_open;
  logic                   tbl_we;
  logic [31:0]            cur;
  logic [COORD_W-1:0]     x0, y0, x1, y1;
  logic [COORD_W-1:0]     exmin, exmax, eymin, eymax;
  logic [COORD_W-1:0]     hxmin, hymin, hxmax, hymax;
  logic                   hb_bad;
  logic                   hit;
  logic [NUM_EDGES-1:0]   hit_bit;

  // The table is frozen during SCAN so every entry is judged against the same contents.
  assign tbl_open = (state_q != S_SCAN);
  assign tbl_we   = edge_wr_en && tbl_open;

  always_comb begin
    valid_d = valid_q;
    if (tbl_open) begin
      if (edge_clr) begin
        valid_d = '0;
      end
      if (edge_wr_en) begin
        valid_d[edge_wr_idx] = 1'b1;
      end
    end
  end

  assign cur   = tbl_q[idx_q];
  assign x0    = cur[COORD_W-1:0];
  assign y0    = cur[2*COORD_W-1:COORD_W];
  assign x1    = cur[3*COORD_W-1:2*COORD_W];
  assign y1    = cur[4*COORD_W-1:3*COORD_W];
  assign exmin = (x0 < x1) ? x0 : x1;
  assign exmax = (x0 < x1) ? x1 : x0;
  assign eymin = (y0 < y1) ? y0 : y1;
  assign eymax = (y0 < y1) ? y1 : y0;

  assign hxmin  = hb_q[COORD_W-1:0];
  assign hymin  = hb_q[2*COORD_W-1:COORD_W];
  assign hxmax  = hb_q[3*COORD_W-1:2*COORD_W];
  assign hymax  = hb_q[4*COORD_W-1:3*COORD_W];
  assign hb_bad = (hxmin > hxmax) || (hymin > hymax);

  assign hit = valid_q[idx_q] && !hb_bad &&
               (exmin <= hxmax) && (exmax >= hxmin) &&
               (eymin <= hymax) && (eymax >= hymin);

  assign hit_bit = NUM_EDGES'(hit) << idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hb_d    = hb_q;
    mask_d  = mask_q;
    any_d   = any_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (hb_start) begin
          state_d = S_SCAN;
          hb_d    = hitbox;
          idx_d   = 4'd0;
          mask_d  = '0;
          any_d   = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_SCAN: begin
        mask_d = mask_q | hit_bit;
        any_d  = |mask_d;
        idx_d  = idx_q + 4'd1;
        if (idx_q == 4'(NUM_EDGES - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      hb_q    <= 32'd0;
      mask_q  <= '0;
      any_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hb_q    <= hb_d;
      mask_q  <= mask_d;
      any_q   <= any_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload needs no reset: the valid bits decide whether it is ever looked at.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[edge_wr_idx] <= edge_wr_data;
    end
  end

  assign hb_done   = done_q;
  assign hb_result = {15'd0, any_q, mask_q};
  assign busy      = (state_q == S_SCAN);

endmodule

// File: tb/tb_edgcol_hb_engine.sv
// Scoreboard bench for edgcol_hb_engine: a reference model predicts each scan result at start time,
// and a negedge monitor compares result, latency and busy length whenever hb_done rises.
module tb_edgcol_hb_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        edge_wr_en;
  logic [3:0]  edge_wr_idx;
  logic [31:0] edge_wr_data;
  logic        edge_clr;
  logic        hb_start;
  logic [31:0] hitbox;
  logic        hb_done;
  logic [31:0] hb_result;
  logic        busy;

  edgcol_hb_engine #(.NUM_EDGES(16), .COORD_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .edge_wr_en(edge_wr_en), .edge_wr_idx(edge_wr_idx), .edge_wr_data(edge_wr_data),
    .edge_clr(edge_clr), .hb_start(hb_start), .hitbox(hitbox),
    .hb_done(hb_done), .hb_result(hb_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          start_edge;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_tab [16];
  bit          m_val [16];
  int          m_left = 0;
  logic [31:0] last_res = 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Two closed intervals intersect iff the larger low end does not pass the smaller high end.
  function automatic logic [31:0] model_scan(input logic [31:0] hb);
    int xmin, ymin, xmax, ymax;
    int ax, ay, bx, by;
    logic [15:0] mask;
    logic [31:0] w;
    xmin = int'(hb[7:0]);
    ymin = int'(hb[15:8]);
    xmax = int'(hb[23:16]);
    ymax = int'(hb[31:24]);
    mask = '0;
    if (xmin <= xmax && ymin <= ymax) begin
      for (int e = 0; e < 16; e++) begin
        if (m_val[e]) begin
          w  = m_tab[e];
          ax = int'(w[7:0]);
          ay = int'(w[15:8]);
          bx = int'(w[23:16]);
          by = int'(w[31:24]);
          if (imax(imin(ax, bx), xmin) <= imin(imax(ax, bx), xmax) &&
              imax(imin(ay, by), ymin) <= imin(imax(ay, by), ymax))
            mask[e] = 1'b1;
        end
      end
    end
    return {15'd0, (mask != 16'd0), mask};
  endfunction

  task automatic step(input bit we, input int idx, input logic [31:0] d,
                      input bit clr, input bit st, input logic [31:0] hb);
    @(negedge clk);
    edge_wr_en   = we;
    edge_wr_idx  = idx[3:0];
    edge_wr_data = d;
    edge_clr     = clr;
    hb_start     = st;
    hitbox       = hb;
    if (m_left == 0) begin
      if (clr) for (int e = 0; e < 16; e++) m_val[e] = 1'b0;
      if (we) begin
        m_tab[idx[3:0]] = d;
        m_val[idx[3:0]] = 1'b1;
      end
      if (st) begin
        sb.push_back('{res: model_scan(hb), start_edge: cyc + 1});
        m_left = 16;
      end
    end else begin
      m_left--;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 32'd0, 0, 0, 32'd0);
  endtask

  task automatic wait_done();
    int k = 0;
    while ((sb.size() != 0 || m_left != 0) && k < 100) begin
      idle(1);
      k++;
    end
    if (k >= 100) begin
      checks++;
      failures++;
      $display("FAIL wait_done timeout pending=%0d required=0", sb.size());
      sb.delete();
      m_left = 0;
    end
  endtask

  task automatic scan(input string nm, input logic [31:0] hb, input logic [31:0] exp);
    step(0, 0, 32'd0, 0, 1, hb);
    wait_done();
    chk(nm, last_res, exp);
  endtask

  // Monitor: every rising hb_done must match the oldest outstanding prediction.
  logic prev_done = 1'b0;
  int   busy_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
      busy_run  = 0;
    end else begin
      if (busy) busy_run++;
      if (hb_done && !prev_done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", hb_result, e.res);
          chk("latency", 32'(cyc - e.start_edge), 32'd16);
          chk("busy_len", 32'(busy_run), 32'd16);
          last_res = hb_result;
        end
        busy_run = 0;
      end
      prev_done = hb_done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hb, d;
    rst_n = 1'b0;
    edge_wr_en = 0; edge_wr_idx = 0; edge_wr_data = 0;
    edge_clr = 0; hb_start = 0; hitbox = 0;
    for (int e = 0; e < 16; e++) begin
      m_val[e] = 1'b0;
      m_tab[e] = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, hb_done}, 32'd0);
    chk("rst_result", hb_result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    scan("empty_table", 32'hFFFF0000, 32'h00000000);

    step(1, 3, 32'h14140A0A, 0, 0, 32'd0);
    step(1, 7, 32'h3C3C3232, 0, 0, 32'd0);
    scan("box_0_15", 32'h0F0F0000, 32'h00010008);
    scan("corner_touch", 32'h1E1E1414, 32'h00010008);
    scan("corner_miss", 32'h1E1E1415, 32'h00000000);
    scan("malformed", 32'h05050A0A, 32'h00000000);

    // Table edits while busy must be ignored.
    step(0, 0, 32'd0, 0, 1, 32'h0F0F0000);
    step(1, 5, 32'h01010000, 0, 0, 32'd0);
    step(0, 0, 32'd0, 1, 0, 32'd0);
    wait_done();
    chk("busy_edits_ignored", last_res, 32'h00010008);
    scan("busy_edits_next", 32'h0F0F0000, 32'h00010008);

    step(1, 2, 32'h02020101, 1, 0, 32'd0);
    scan("clr_plus_write", 32'hFFFF0000, 32'h00010004);

    // Reset in the middle of a scan.
    step(1, 9, 32'h05050404, 0, 0, 32'd0);
    step(0, 0, 32'd0, 0, 1, 32'hFFFF0000);
    idle(7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", {31'd0, hb_done}, 32'd0);
    chk("midrst_result", hb_result, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    m_left = 0;
    for (int e = 0; e < 16; e++) m_val[e] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    chk("no_done_after_rst", {31'd0, hb_done}, 32'd0);
    step(1, 4, 32'h0A0A1414, 0, 0, 32'd0);
    scan("after_rst", 32'h0F0F0000, 32'h00010010);

    // Randomized mix of writes, clears and starts, some colliding with scans.
    for (int i = 0; i < 600; i++) begin
      d  = $urandom;
      hb = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        hb[23:16] = 8'($urandom_range(int'(hb[7:0]), 255));
        hb[31:24] = 8'($urandom_range(int'(hb[15:8]), 255));
      end
      step($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)), d,
           $urandom_range(0, 40) == 0, $urandom_range(0, 5) == 0, hb);
    end
    wait_done();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
